data_wb_initiator: RTL

- Data-side Wishbone (pipelined mode) initiator for the memory-access stage. It is the other end of the main_memory `wb_*` responder port.
- Accepts one load/store request from the pipeline and runs exactly one Wishbone single cycle.
- Performs byte/half/word lane steering and sign/zero extension.
- Returns the result with a one-cycle `done` pulse.

---
 rtl/data_wb_initiator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_wb_initiator.sv
// Data-side Wishbone (pipelined) initiator: one load/store request becomes one single bus cycle.
// Optional bus timeout enabled by defining BUS_TIMEOUT_EN.
module data_wb_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_wr_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    input  logic [2:0]  req_funct3,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rd_data,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_wr_en,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wr_data,
    output logic [3:0]  wb_wr_sel,
    input  logic        wb_ack,
    input  logic        wb_stall,
    input  logic [31:0] wb_rd_data
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, RESP} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [2:0]  f3;
    logic        legal;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ext;
    logic        tmo;
    logic        ack_fin;
    logic        tmo_fin;

    always_comb begin
        case (req_funct3)
            3'd0:    legal = 1'b1;
            3'd1:    legal = !req_addr[0];
            3'd2:    legal = (req_addr[1:0] == 2'b00);
            3'd4:    legal = !req_wr_en;
            3'd5:    legal = !req_wr_en && !req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        sel   = 4'b1111;
        wdata = '0;
        if (req_wr_en) begin
            case (req_funct3[1:0])
                2'd0: begin
                    sel   = 4'b0001 << req_addr[1:0];
                    wdata = {4{req_wr_data[7:0]}};
                end
                2'd1: begin
                    sel   = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{req_wr_data[15:0]}};
                end
                default: wdata = req_wr_data;
            endcase
        end
    end

    // Lane extraction uses the byte offset latched at accept time.
    always_comb begin
        case (lane)
            2'd0:    rb = wb_rd_data[7:0];
            2'd1:    rb = wb_rd_data[15:8];
            2'd2:    rb = wb_rd_data[23:16];
            default: rb = wb_rd_data[31:24];
        endcase
        rh = lane[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
        case (f3)
            3'd0:    ext = {{24{rb[7]}}, rb};
            3'd1:    ext = {{16{rh[15]}}, rh};
            3'd4:    ext = {24'd0, rb};
            3'd5:    ext = {16'd0, rh};
            default: ext = wb_rd_data;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else if (state == IDLE)
            tcnt <= '0;
        else if (state == STROBE || state == WAIT_ACK)
            tcnt <= tcnt + 1'b1;
    end

    assign tmo = (tcnt == TLAST);
`else
    assign tmo = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // An ack on the same edge as the timeout wins.
    assign ack_fin = ((state == STROBE) && !wb_stall && wb_ack) ||
                     ((state == WAIT_ACK) && wb_ack);
    assign tmo_fin = ((state == STROBE) || (state == WAIT_ACK)) && !ack_fin && tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rd_data    <= '0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_addr    <= '0;
            wb_wr_data <= '0;
            wb_wr_sel  <= '0;
            lane       <= '0;
            f3         <= '0;
        end else begin
            done <= 1'b0;
            if (ack_fin || tmo_fin) begin
                wb_cyc <= 1'b0;
                wb_stb <= 1'b0;
                done   <= 1'b1;
                error  <= tmo_fin;
                state  <= RESP;
                if (ack_fin && !wb_wr_en)
                    rd_data <= ext;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            busy <= 1'b1;
                            lane <= req_addr[1:0];
                            f3   <= req_funct3;
                            if (!legal) begin
                                state <= RESP;
                                done  <= 1'b1;
                                error <= 1'b1;
                            end else begin
                                state      <= STROBE;
                                error      <= 1'b0;
                                wb_cyc     <= 1'b1;
                                wb_stb     <= 1'b1;
                                wb_wr_en   <= req_wr_en;
                                wb_addr    <= {req_addr[31:2], 2'b00};
                                wb_wr_data <= wdata;
                                wb_wr_sel  <= sel;
                            end
                        end
                    end
                    STROBE: begin
                        if (!wb_stall) begin
                            wb_stb <= 1'b0;
                            state  <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: ;
                    RESP: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
